// File: rtl/pulse_src_if.sv
// Pulse-bridge bundle between the two pulse sequencers and the source arbiter.
// Ports: req0/req1, source 0/1 forward/back/df lines in; gnt0/gnt1, change,
// gated forward/back/df and busy out; fault/fault_clr with PULSE_SRC_WDOG_EN.
interface pulse_src_if;
    logic req0;
    logic req1;
    logic forward1;
    logic back1;
    logic df1;
    logic forward2;
    logic back2;
    logic df2;
    logic gnt0;
    logic gnt1;
    logic change;
    logic forward;
    logic back;
    logic df;
    logic busy;
`ifdef PULSE_SRC_WDOG_EN
    logic fault;
    logic fault_clr;
`endif

    modport master (
        output req0, req1,
        output forward1, back1, df1,
        output forward2, back2, df2,
`ifdef PULSE_SRC_WDOG_EN
        output fault_clr,
        input  fault,
`endif
        input  gnt0, gnt1, change,
        input  forward, back, df, busy
    );

    modport slave (
        input  req0, req1,
        input  forward1, back1, df1,
        input  forward2, back2, df2,
`ifdef PULSE_SRC_WDOG_EN
        input  fault_clr,
        output fault,
`endif
        output gnt0, gnt1, change,
        output forward, back, df, busy
    );
endinterface

// File: rtl/pulse_src_arbiter.sv
// Two-source pulse-bridge arbiter with blanking dead-time on select changes.
// Ports: clk, rst (async, active-high), bus (pulse_src_if.slave).
// Optional hold watchdog enabled by macro PULSE_SRC_WDOG_EN (adds fault/fault_clr).
module pulse_src_arbiter #(
    parameter int DEAD_CYC = 8,
    parameter int CNT_W    = 8
`ifdef PULSE_SRC_WDOG_EN
    ,
    parameter int MAX_HOLD = 65535
`endif
) (
    input  logic       clk,
    input  logic       rst,
    pulse_src_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        OWN  = 2'd2
    } state_t;

    state_t           state_q;
    logic             change_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             fwd_q;
    logic             back_q;
    logic             df_q;
    logic             busy_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    logic             elig0;
    logic             elig1;
    logic             any_req;
    logic             win;
    logic             own_req;
    logic [2:0]       pul0;
    logic [2:0]       pul1;
    logic [2:0]       sel_pul;

`ifdef PULSE_SRC_WDOG_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              fault_q;
    // A timed-out source stays ineligible until its req is seen low.
    logic              blk0_q;
    logic              blk1_q;
`endif

    always_comb begin
        pul0    = {bus.forward1, bus.back1, bus.df1};
        pul1    = {bus.forward2, bus.back2, bus.df2};
        // change_q already equals the grantee on every path into OWN.
        sel_pul = change_q ? pul1 : pul0;
`ifdef PULSE_SRC_WDOG_EN
        elig0   = bus.req0 & ~blk0_q;
        elig1   = bus.req1 & ~blk1_q;
`else
        elig0   = bus.req0;
        elig1   = bus.req1;
`endif
        any_req = elig0 | elig1;
        // Round-robin on a tie: the source that did not own last wins.
        win     = (elig0 & elig1) ? ~last_q : elig1;
        own_req = change_q ? bus.req1 : bus.req0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            change_q <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            fwd_q    <= 1'b0;
            back_q   <= 1'b0;
            df_q     <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
`ifdef PULSE_SRC_WDOG_EN
            hold_q   <= '0;
            fault_q  <= 1'b0;
            blk0_q   <= 1'b0;
            blk1_q   <= 1'b0;
`endif
        end else begin
            // Outputs and grants are blanked unless the next state is OWN.
            fwd_q  <= 1'b0;
            back_q <= 1'b0;
            df_q   <= 1'b0;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
`ifdef PULSE_SRC_WDOG_EN
            if (!bus.req0) blk0_q <= 1'b0;
            if (!bus.req1) blk1_q <= 1'b0;
            if (bus.fault_clr) fault_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        busy_q <= 1'b1;
                        if (win == change_q) begin
                            state_q <= OWN;
                            gnt0_q  <= ~win;
                            gnt1_q  <= win;
                            {fwd_q, back_q, df_q} <= sel_pul;
`ifdef PULSE_SRC_WDOG_EN
                            hold_q  <= '0;
`endif
                        end else begin
                            state_q  <= DEAD;
                            change_q <= win;
                            cnt_q    <= CNT_W'(DEAD_CYC);
                        end
                    end
                end
                DEAD: begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q <= '0;
                        // The grantee may have dropped its request while blanked.
                        if (own_req) begin
                            state_q <= OWN;
                            gnt0_q  <= ~change_q;
                            gnt1_q  <= change_q;
                            {fwd_q, back_q, df_q} <= sel_pul;
`ifdef PULSE_SRC_WDOG_EN
                            hold_q  <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                OWN: begin
                    if (!own_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        last_q  <= change_q;
`ifdef PULSE_SRC_WDOG_EN
                    end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        last_q  <= change_q;
                        fault_q <= 1'b1;
                        if (change_q) blk1_q <= 1'b1;
                        else          blk0_q <= 1'b1;
`endif
                    end else begin
                        gnt0_q <= ~change_q;
                        gnt1_q <= change_q;
                        {fwd_q, back_q, df_q} <= sel_pul;
`ifdef PULSE_SRC_WDOG_EN
                        hold_q <= hold_q + HOLD_W'(1);
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.change  = change_q;
    assign bus.forward = fwd_q;
    assign bus.back    = back_q;
    assign bus.df      = df_q;
    assign bus.busy    = busy_q;
`ifdef PULSE_SRC_WDOG_EN
    assign bus.fault   = fault_q;
`endif

endmodule

// File: tb/tb_pulse_src_arbiter.sv
// Self-checking bench for pulse_src_arbiter: vector table, corner sequences,
// and a randomized run against a timestamp-based reference model.
module tb_pulse_src_arbiter;

    localparam int DC = 8;
`ifdef PULSE_SRC_WDOG_EN
    localparam int MH = 16;
`endif

    logic clk = 1'b0;
    logic rst;

    pulse_src_if bus ();

    pulse_src_arbiter #(
        .DEAD_CYC(DC),
        .CNT_W   (8)
`ifdef PULSE_SRC_WDOG_EN
        ,
        .MAX_HOLD(MH)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit       r0;
        bit       r1;
        bit [2:0] p1;
        bit [2:0] p2;
        bit [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic bit [6:0] e(bit g0, bit g1, bit ch, bit [2:0] f, bit bz);
        return {g0, g1, ch, f, bz};
    endfunction

    function automatic vec_t mk(bit r0, bit r1, bit [2:0] p1, bit [2:0] p2, bit [6:0] ex);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.p1 = p1; v.p2 = p2; v.exp = ex;
        return v;
    endfunction

    function automatic logic [6:0] core();
        return {bus.gnt0, bus.gnt1, bus.change,
                bus.forward, bus.back, bus.df, bus.busy};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        {bus.forward1, bus.back1, bus.df1} = 3'b000;
        {bus.forward2, bus.back2, bus.df2} = 3'b000;
`ifdef PULSE_SRC_WDOG_EN
        bus.fault_clr = 1'b0;
`endif
    endtask

    // Reference model: ownership, pending switch with absolute grant time,
    // and grant start time for the hold limit.
    int       m_owner;
    bit       m_pend;
    int       m_sel;
    int       m_last;
    longint   m_grant_at;
    longint   m_own_since;
    bit [2:0] m_out;
    bit       m_fault;
    bit       m_blk0;
    bit       m_blk1;
    longint   cyc;

    task automatic model_reset();
        m_owner = -1; m_pend = 0; m_sel = 0; m_last = 1;
        m_grant_at = 0; m_own_since = 0; m_out = 0;
        m_fault = 0; m_blk0 = 0; m_blk1 = 0; cyc = 0;
    endtask

    task automatic model_step(input bit r0, input bit r1,
                              input bit [2:0] p0, input bit [2:0] p1,
                              input bit clr);
        bit [2:0] nxt;
        bit       e0;
        bit       e1;
        int       w;
        nxt = 3'b000;
`ifdef PULSE_SRC_WDOG_EN
        if (!r0) m_blk0 = 0;
        if (!r1) m_blk1 = 0;
        if (clr) m_fault = 0;
`else
        if (clr) m_fault = 0;
`endif
        if (m_owner >= 0) begin
            if (!(m_owner == 1 ? r1 : r0)) begin
                m_last = m_owner;
                m_owner = -1;
`ifdef PULSE_SRC_WDOG_EN
            end else if (cyc - m_own_since == MH) begin
                m_last = m_owner;
                if (m_owner == 1) m_blk1 = 1; else m_blk0 = 1;
                m_fault = 1;
                m_owner = -1;
`endif
            end else begin
                nxt = (m_owner == 1) ? p1 : p0;
            end
        end else if (m_pend) begin
            if (cyc == m_grant_at - 1) begin
                m_pend = 0;
                if (m_sel == 1 ? r1 : r0) begin
                    m_owner = m_sel;
                    m_own_since = m_grant_at;
                    nxt = (m_sel == 1) ? p1 : p0;
                end
            end
        end else begin
            e0 = r0 && !m_blk0;
            e1 = r1 && !m_blk1;
            if (e0 || e1) begin
                w = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
                if (w == m_sel) begin
                    m_owner = w;
                    m_own_since = cyc + 1;
                    nxt = (w == 1) ? p1 : p0;
                end else begin
                    m_sel = w;
                    m_pend = 1;
                    m_grant_at = cyc + 1 + DC;
                end
            end
        end
        m_out = nxt;
        cyc++;
    endtask

    function automatic bit [6:0] model_exp();
        return {m_owner == 0, m_owner == 1, m_sel[0], m_out,
                (m_owner >= 0) || m_pend};
    endfunction

    initial begin
        bit r0;
        bit r1;
        bit [2:0] p0;
        bit [2:0] p1;
        bit clr;

        rst = 1'b1;
        drive_idle();
        #2;
        check("reset_state", {1'b0, core()}, 8'h00);
`ifdef PULSE_SRC_WDOG_EN
        check("reset_fault", {7'b0, bus.fault}, 8'h00);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Same-source grant, switch with dead-time, tie, drop during dead-time.
        tbl.push_back(mk(0, 0, 3'b111, 3'b111, e(0, 0, 0, 3'b000, 0)));
        tbl.push_back(mk(1, 0, 3'b101, 3'b111, e(1, 0, 0, 3'b101, 1)));
        tbl.push_back(mk(1, 0, 3'b010, 3'b111, e(1, 0, 0, 3'b010, 1)));
        tbl.push_back(mk(1, 0, 3'b111, 3'b000, e(1, 0, 0, 3'b111, 1)));
        tbl.push_back(mk(0, 0, 3'b111, 3'b111, e(0, 0, 0, 3'b000, 0)));
        for (int i = 0; i < DC; i++)
            tbl.push_back(mk(0, 1, 3'b111, 3'b111, e(0, 0, 1, 3'b000, 1)));
        tbl.push_back(mk(0, 1, 3'b000, 3'b011, e(0, 1, 1, 3'b011, 1)));
        tbl.push_back(mk(1, 1, 3'b111, 3'b100, e(0, 1, 1, 3'b100, 1)));
        tbl.push_back(mk(1, 0, 3'b111, 3'b111, e(0, 0, 1, 3'b000, 0)));
        tbl.push_back(mk(1, 0, 3'b111, 3'b111, e(0, 0, 0, 3'b000, 1)));
        for (int i = 1; i < DC; i++)
            tbl.push_back(mk(0, 0, 3'b111, 3'b111, e(0, 0, 0, 3'b000, 1)));
        tbl.push_back(mk(0, 0, 3'b111, 3'b111, e(0, 0, 0, 3'b000, 0)));
        tbl.push_back(mk(1, 1, 3'b110, 3'b001, e(1, 0, 0, 3'b110, 1)));
        tbl.push_back(mk(0, 1, 3'b111, 3'b111, e(0, 0, 0, 3'b000, 0)));
        tbl.push_back(mk(0, 1, 3'b111, 3'b111, e(0, 0, 1, 3'b000, 1)));

        foreach (tbl[i]) begin
            bus.req0 = tbl[i].r0;
            bus.req1 = tbl[i].r1;
            {bus.forward1, bus.back1, bus.df1} = tbl[i].p1;
            {bus.forward2, bus.back2, bus.df2} = tbl[i].p2;
            tick();
            check($sformatf("vec%0d", i), {1'b0, core()}, {1'b0, tbl[i].exp});
        end

        // Reset while blanking with counter at 4, req1 kept high.
        for (int k = 0; k < 4; k++) begin
            tick();
            check("dead_pre_rst", {1'b0, core()}, {1'b0, e(0, 0, 1, 3'b000, 1)});
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_dead", {1'b0, core()}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rerun_dead_start", {1'b0, core()}, {1'b0, e(0, 0, 1, 3'b000, 1)});
        for (int k = 0; k < DC - 1; k++) begin
            tick();
            check("rerun_dead", {1'b0, core()}, {1'b0, e(0, 0, 1, 3'b000, 1)});
        end
        {bus.forward2, bus.back2, bus.df2} = 3'b010;
        tick();
        check("rerun_gnt1", {1'b0, core()}, {1'b0, e(0, 1, 1, 3'b010, 1)});

        // Simultaneous requests from reset, then hand-over to source 1.
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        {bus.forward1, bus.back1, bus.df1} = 3'b100;
        {bus.forward2, bus.back2, bus.df2} = 3'b111;
        tick();
        check("tie_gnt0", {1'b0, core()}, {1'b0, e(1, 0, 0, 3'b100, 1)});
        bus.req0 = 1'b0;
        tick();
        check("tie_release", {1'b0, core()}, {1'b0, e(0, 0, 0, 3'b000, 0)});
        tick();
        check("tie_switch", {1'b0, core()}, {1'b0, e(0, 0, 1, 3'b000, 1)});
        for (int k = 0; k < DC - 1; k++) begin
            tick();
            check("tie_dead", {1'b0, core()}, {1'b0, e(0, 0, 1, 3'b000, 1)});
        end
        {bus.forward2, bus.back2, bus.df2} = 3'b101;
        tick();
        check("tie_gnt1", {1'b0, core()}, {1'b0, e(0, 1, 1, 3'b101, 1)});
        bus.req1 = 1'b0;
        tick();
        check("tie_rel1", {1'b0, core()}, {1'b0, e(0, 0, 1, 3'b000, 0)});

`ifdef PULSE_SRC_WDOG_EN
        // Hold watchdog: revoke, sticky fault, re-grant only after req low.
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b1;
        tick();
        check("wd_grant", {7'b0, bus.gnt0}, 8'h01);
        for (int k = 1; k <= MH; k++) begin
            tick();
            check("wd_hold", {7'b0, bus.gnt0}, 8'h01);
        end
        tick();
        check("wd_revoke", {6'b0, bus.gnt0, bus.busy}, 8'h00);
        check("wd_fault", {7'b0, bus.fault}, 8'h01);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wd_blocked", {6'b0, bus.gnt0, bus.fault}, 8'h01);
        end
        bus.req0 = 1'b0;
        tick();
        bus.req0 = 1'b1;
        tick();
        check("wd_regrant", {6'b0, bus.gnt0, bus.fault}, 8'h03);
        bus.req0 = 1'b0;
        bus.fault_clr = 1'b1;
        tick();
        check("wd_clr", {6'b0, bus.gnt0, bus.fault}, 8'h00);
        bus.fault_clr = 1'b0;
`endif

        // Randomized run against the reference model.
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        r0 = 0;
        r1 = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 15) == 0) r0 = ~r0;
            if ($urandom_range(0, 15) == 0) r1 = ~r1;
            p0 = 3'($urandom);
            p1 = 3'($urandom);
            clr = ($urandom_range(0, 63) == 0);
            bus.req0 = r0;
            bus.req1 = r1;
            {bus.forward1, bus.back1, bus.df1} = p0;
            {bus.forward2, bus.back2, bus.df2} = p1;
`ifdef PULSE_SRC_WDOG_EN
            bus.fault_clr = clr;
`else
            clr = 1'b0;
`endif
            model_step(r0, r1, p0, p1, clr);
            tick();
            check("rand_out", {1'b0, core()}, {1'b0, model_exp()});
            check("rand_excl", {7'b0, bus.gnt0 & bus.gnt1}, 8'h00);
`ifdef PULSE_SRC_WDOG_EN
            check("rand_fault", {7'b0, bus.fault}, {7'b0, m_fault});
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
